mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It replaces the separate instruction and data memories with one unified memory. It runs one transaction at a time, arbitrates with data priority and a fetch anti-starvation guard, and returns a one-cycle `ready` pulse per port. The pipeline's stall/hold logic keys off these pulses.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owner,
// and the width used by the latency and starvation counters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port,
// fixed-latency memory; one transaction at a time, data-first with a fetch guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_ready,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_ready,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] STARVE_LIM = LAT_W'(STARVE_MAX);

    state_t           state;
    owner_t           owner;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] starve_cnt;
    logic             drop;

    logic             grant_if;
    logic             grant_d;
    logic             fetch_cancel;

    // Arbitration terms only feed registers; every output stays registered.
    always_comb begin
        grant_if     = 1'b0;
        grant_d      = 1'b0;
        fetch_cancel = 1'b0;
        grant_if     = if_req && !if_cancel && (!d_req || starve_cnt == STARVE_LIM);
        grant_d      = d_req && !grant_if;
        fetch_cancel = (owner == OWN_IF) && if_cancel;
    end

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked
    // branch; all state updates use <= so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        state  <= ACCESS;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        drop   <= 1'b0;
                        if (grant_if) begin
                            owner      <= OWN_IF;
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_D;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            if (if_req && starve_cnt != STARVE_LIM)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (fetch_cancel)
                        drop <= 1'b1;
                    if (mem_we) begin
                        state   <= DONE;
                        d_ready <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_LAST;
                    end
                end

                WAIT: begin
                    if (fetch_cancel)
                        drop <= 1'b1;
                    if (lat_cnt == '0) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_rdata;
                        end else if (!drop && !if_cancel) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    drop  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 2, 1, 15) each with a private
// behavioural memory; instance 0 carries the main functional sequence.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_v [3];
    logic        d_req_v  [3];
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic        if_cancel;

    int nvec  = 0;
    int nfail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        logic        if_ready, d_ready, busy, mem_en, mem_we;
        logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, rdata;
        logic [31:0] mem [64];
        int          cnt = 0;
        logic [5:0]  ra  = '0;

        mem_port_arbiter #(
            .DWIDTH(32), .AWIDTH(32), .MEM_LAT(LAT), .STARVE_MAX(3)
        ) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req_v[g]), .if_addr(if_addr), .if_cancel(if_cancel),
            .if_ready(if_ready), .if_rdata(if_rdata),
            .d_req(d_req_v[g]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ready(d_ready), .d_rdata(d_rdata), .busy(busy),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(rdata)
        );

        // Word i holds 0x1000_0000*(g+1)+i, except 0x40 and 0x08.
        initial begin
            rdata = 32'hBAD0_BAD0;
            for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 * (g + 1) + i;
            mem[16] = 32'hDEAD_BEEF;
            mem[2]  = 32'h0BAD_F00D;
        end

        // Read data is valid only in the cycle exactly LAT after the mem_en cycle.
        always @(posedge clk) begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] = mem_wdata;
            if (mem_en && !mem_we) begin
                cnt = LAT;
                ra  = mem_addr[7:2];
            end
            rdata <= 32'hBAD0_BAD0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) rdata <= mem[ra];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(input int budget, output int cyc, output logic seen_if);
        cyc     = 0;
        seen_if = 1'b0;
        do begin
            tick();
            cyc++;
            if (gen_dut[0].if_ready) seen_if = 1'b1;
        end while (!gen_dut[0].d_ready && cyc < budget);
    endtask

    initial begin
        int          cyc;
        int          n;
        int          lat1;
        int          lat2;
        logic        seen;
        logic [7:0]  order;

        rst       = 1'b0;
        if_addr   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        d_we      = 1'b0;
        if_cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_req_v[i] = 1'b0;
            d_req_v[i]  = 1'b0;
        end

        // Reset state
        tick();
        tick();
        check("rst_busy",     {31'd0, gen_dut[0].busy},     32'd0);
        check("rst_mem_en",   {31'd0, gen_dut[0].mem_en},   32'd0);
        check("rst_mem_addr", gen_dut[0].mem_addr,          32'd0);
        check("rst_d_rdata",  gen_dut[0].d_rdata,           32'd0);
        check("rst_if_rdata", gen_dut[0].if_rdata,          32'd0);
        rst = 1'b1;
        tick();

        // Lone load of 0x40
        d_addr = 32'h40; d_we = 1'b0; d_req_v[0] = 1'b1;
        tick();
        check("ld_mem_en",   {31'd0, gen_dut[0].mem_en}, 32'd1);
        check("ld_mem_we",   {31'd0, gen_dut[0].mem_we}, 32'd0);
        check("ld_mem_addr", gen_dut[0].mem_addr,        32'h40);
        check("ld_busy",     {31'd0, gen_dut[0].busy},   32'd1);
        wait_d(10, cyc, seen);
        check("ld_latency",  cyc + 1,                    32'd4);
        check("ld_rdata",    gen_dut[0].d_rdata,         32'hDEAD_BEEF);
        check("ld_no_if",    {31'd0, seen},              32'd0);
        d_req_v[0] = 1'b0;
        tick();
        check("ld_pulse_end", {31'd0, gen_dut[0].d_ready}, 32'd0);
        check("ld_idle",      {31'd0, gen_dut[0].busy},    32'd0);

        // Lone store of 0x1234 to 0x10, then read it back
        d_addr = 32'h10; d_wdata = 32'h1234; d_we = 1'b1; d_req_v[0] = 1'b1;
        tick();
        check("st_mem_en",    {31'd0, gen_dut[0].mem_en}, 32'd1);
        check("st_mem_we",    {31'd0, gen_dut[0].mem_we}, 32'd1);
        check("st_mem_addr",  gen_dut[0].mem_addr,        32'h10);
        check("st_mem_wdata", gen_dut[0].mem_wdata,       32'h1234);
        tick();
        check("st_ready", {31'd0, gen_dut[0].d_ready}, 32'd1);
        d_req_v[0] = 1'b0;
        tick();
        d_we = 1'b0; d_req_v[0] = 1'b1;
        wait_d(10, cyc, seen);
        check("st_rb_latency", cyc, 32'd4);
        check("st_rb_rdata",   gen_dut[0].d_rdata, 32'h1234);
        d_req_v[0] = 1'b0;
        tick();

        // Both ports held: expect D,D,D,IF,D,D,D,IF
        d_addr = 32'h40; if_addr = 32'h80; d_we = 1'b0;
        d_req_v[0] = 1'b1; if_req_v[0] = 1'b1;
        order = '0;
        n     = 0;
        for (int c = 0; c < 100 && n < 8; c++) begin
            tick();
            if (gen_dut[0].d_ready) n++;
            if (gen_dut[0].if_ready) begin
                order[n[2:0]] = 1'b1;
                n++;
            end
            if (n == 8) begin
                d_req_v[0]  = 1'b0;
                if_req_v[0] = 1'b0;
            end
        end
        check("starve_txns",   n,                     32'd8);
        check("starve_order",  {24'd0, order},        32'h88);
        check("starve_cnt",    {28'd0, gen_dut[0].dut.starve_cnt}, 32'd0);
        check("starve_ifdata", gen_dut[0].if_rdata,   32'h1000_0020);
        check("starve_ddata",  gen_dut[0].d_rdata,    32'hDEAD_BEEF);
        tick();
        check("starve_idle", {31'd0, gen_dut[0].busy}, 32'd0);

        // Fetch of 0x8 cancelled during WAIT
        if_addr = 32'h8; if_req_v[0] = 1'b1;
        tick();
        check("cx_mem_en",   {31'd0, gen_dut[0].mem_en}, 32'd1);
        check("cx_mem_addr", gen_dut[0].mem_addr,        32'h8);
        tick();
        if_cancel = 1'b1; if_req_v[0] = 1'b0;
        tick();
        if_cancel = 1'b0;
        check("cx_busy_wait", {31'd0, gen_dut[0].busy}, 32'd1);
        tick();
        check("cx_done_busy", {31'd0, gen_dut[0].busy},     32'd1);
        check("cx_no_ready",  {31'd0, gen_dut[0].if_ready}, 32'd0);
        tick();
        check("cx_idle",      {31'd0, gen_dut[0].busy},     32'd0);
        check("cx_if_rdata",  gen_dut[0].if_rdata,          32'h1000_0020);

        // Cancel in IDLE blocks the fetch grant
        if_req_v[0] = 1'b1; if_cancel = 1'b1;
        tick();
        check("cx_idle_no_en",   {31'd0, gen_dut[0].mem_en}, 32'd0);
        check("cx_idle_no_busy", {31'd0, gen_dut[0].busy},   32'd0);
        if_req_v[0] = 1'b0; if_cancel = 1'b0;
        tick();

        // Reset during WAIT of a load
        d_addr = 32'h40; d_we = 1'b0; d_req_v[0] = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("mr_busy",     {31'd0, gen_dut[0].busy},    32'd0);
        check("mr_d_ready",  {31'd0, gen_dut[0].d_ready}, 32'd0);
        check("mr_mem_addr", gen_dut[0].mem_addr,         32'd0);
        check("mr_d_rdata",  gen_dut[0].d_rdata,          32'd0);
        check("mr_state",    {30'd0, gen_dut[0].dut.state}, 32'd0);
        rst = 1'b1; d_req_v[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (gen_dut[0].d_ready) seen = 1'b1;
        end
        check("mr_no_late_ready", {31'd0, seen}, 32'd0);
        d_addr = 32'h10; d_req_v[0] = 1'b1;
        wait_d(10, cyc, seen);
        check("mr_fresh_latency", cyc,                32'd4);
        check("mr_fresh_rdata",   gen_dut[0].d_rdata, 32'h1234);
        d_req_v[0] = 1'b0;
        tick();

        // MEM_LAT = 1 and 15 lone reads
        d_addr = 32'h40; d_we = 1'b0; d_req_v[1] = 1'b1; d_req_v[2] = 1'b1;
        lat1 = -1;
        lat2 = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (gen_dut[1].d_ready && lat1 < 0) begin
                lat1 = c;
                d_req_v[1] = 1'b0;
            end
            if (gen_dut[2].d_ready && lat2 < 0) begin
                lat2 = c;
                d_req_v[2] = 1'b0;
            end
        end
        d_req_v[1] = 1'b0; d_req_v[2] = 1'b0;
        check("lat1_ready",  lat1,               32'd3);
        check("lat15_ready", lat2,               32'd17);
        check("lat1_rdata",  gen_dut[1].d_rdata, 32'hDEAD_BEEF);
        check("lat15_rdata", gen_dut[2].d_rdata, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
